// File: rtl/dlx_fetch_queue.sv
// dlx_fetch_queue
// Instruction-fetch stage for the pipelined DLX core. Drives the instruction
// ROM address, captures returned words (tagged with their PC) into a
// DEPTH-entry prefetch queue and presents them to ID via valid/ready.
// A redirect from EX flushes the queue and restarts fetch at the target.
//
// Ports:
//   clk          : clock, all state updates on rising edge
//   reset        : synchronous, active-high reset
//   i_address    : ROM fetch address (current fetch PC), registered
//   i_data_valid : ROM word for i_address is valid this cycle
//   i_data_read  : ROM word for i_address
//   redirect     : EX requests PC change (taken branch/jump)
//   redirect_pc  : target PC for redirect (bits [1:0] are ignored)
//   out_valid    : head entry is valid for ID
//   out_ready    : ID accepts head entry this cycle
//   out_instr    : head instruction word (holds last value when invalid)
//   out_pc       : PC of head instruction (holds last value when invalid)
//   occupancy    : number of valid queue entries, 0..DEPTH
module dlx_fetch_queue #(
  parameter int                 XLEN     = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [XLEN-1:0]    RESET_PC = '0,
  parameter int unsigned        PC_STEP  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [XLEN-1:0]            i_address,
  input  logic                       i_data_valid,
  input  logic [XLEN-1:0]            i_data_read,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_instr,
  output logic [XLEN-1:0]            out_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  // Queue storage (no reset needed: only read when the entry is valid).
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;

  logic            pop_s;
  logic            push_s;
  logic [OW-1:0]   occ_after_pop_s;
  logic [PW-1:0]   head_adv_s;

  // Handshake decode and next-state computation.
  always_comb begin
    pop_s           = valid_q & out_ready;
    push_s          = i_data_valid & ~redirect &
                      ((occ_q < OW'(DEPTH)) | pop_s);
    occ_after_pop_s = occ_q - OW'(pop_s);
    head_adv_s      = head_q + PW'(pop_s);

    head_d      = head_adv_s;
    tail_d      = tail_q;
    occ_d       = occ_q;
    fetch_pc_d  = fetch_pc_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    if (redirect) begin
      // Flush; a concurrent pop is simply absorbed by the flush.
      head_d     = '0;
      tail_d     = '0;
      occ_d      = '0;
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      if (push_s) begin
        tail_d     = tail_q + PW'(1);
        fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      end else begin
        tail_d     = tail_q;
      end

      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase

      // Output registers track the head that will exist next cycle. When the
      // queue drains to empty, they keep their last value.
      if (occ_after_pop_s != '0) begin
        out_instr_d = instr_mem_q[head_adv_s];
        out_pc_d    = pc_mem_q[head_adv_s];
      end else if (push_s) begin
        out_instr_d = i_data_read;
        out_pc_d    = fetch_pc_q;
      end else begin
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
      end
    end

    valid_d = (occ_d != '0);
  end

  // Control and output state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      fetch_pc_q  <= RESET_PC;
      valid_q     <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      fetch_pc_q  <= fetch_pc_d;
      valid_q     <= valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // Queue storage write at the tail on push.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      instr_mem_q[tail_q] <= i_data_read;
      pc_mem_q[tail_q]    <= fetch_pc_q;
    end
  end

  assign i_address = fetch_pc_q;
  assign out_valid = valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_dlx_fetch_queue.sv
// Directed, table-driven bench for dlx_fetch_queue. Each table row gives the
// inputs driven for one cycle and the outputs expected right after the
// following rising edge. A second instance with RESET_PC near the top of the
// address space exercises PC wrap-around.
module tb_dlx_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address;
  logic        i_data_valid;
  logic [31:0] i_data_read;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  occupancy;

  logic [31:0] w_address;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [2:0]  w_occ;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dlx_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .i_address(i_address),
    .i_data_valid(i_data_valid), .i_data_read(i_data_read),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .occupancy(occupancy)
  );

  dlx_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_wrap (
    .clk(clk), .reset(reset), .i_address(w_address),
    .i_data_valid(i_data_valid), .i_data_read(i_data_read),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(w_valid), .out_ready(out_ready),
    .out_instr(w_instr), .out_pc(w_pc), .occupancy(w_occ)
  );

  typedef struct {
    logic        rst;
    logic        dv;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [2:0]  e_occ;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic dv, input logic [31:0] data,
                     input logic redir, input logic [31:0] rpc, input logic rdy,
                     input logic e_valid, input logic [31:0] e_instr,
                     input logic [31:0] e_pc, input logic [2:0] e_occ,
                     input logic [31:0] e_addr);
    vec_t v;
    v.rst = rst; v.dv = dv; v.data = data; v.redir = redir; v.rpc = rpc;
    v.rdy = rdy; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
    v.e_occ = e_occ; v.e_addr = e_addr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then wait past the rising edge.
  task automatic drive(input logic rst, input logic dv, input logic [31:0] data,
                       input logic redir, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    reset = rst; i_data_valid = dv; i_data_read = data;
    redirect = redir; redirect_pc = rpc; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; i_data_valid = 1'b0; i_data_read = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;

    //   rst  dv   data          rdr  rpc           rdy  | vld  instr         pc            occ   addr
    add(1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0,  1'b0, 32'h0,      32'h0,      3'd0, 32'h0);
    // streaming with ID always ready
    add(1'b0, 1'b1, 32'hA0,     1'b0, 32'h0,      1'b1,  1'b1, 32'hA0,     32'h0,      3'd1, 32'h4);
    add(1'b0, 1'b1, 32'hA1,     1'b0, 32'h0,      1'b1,  1'b1, 32'hA1,     32'h4,      3'd1, 32'h8);
    add(1'b0, 1'b1, 32'hA2,     1'b0, 32'h0,      1'b1,  1'b1, 32'hA2,     32'h8,      3'd1, 32'hC);
    add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1,  1'b0, 32'hA2,     32'h8,      3'd0, 32'hC);
    // fill to full with ID stalled; extra words ignored, address held
    add(1'b0, 1'b1, 32'hB0,     1'b0, 32'h0,      1'b0,  1'b1, 32'hB0,     32'hC,      3'd1, 32'h10);
    add(1'b0, 1'b1, 32'hB1,     1'b0, 32'h0,      1'b0,  1'b1, 32'hB0,     32'hC,      3'd2, 32'h14);
    add(1'b0, 1'b1, 32'hB2,     1'b0, 32'h0,      1'b0,  1'b1, 32'hB0,     32'hC,      3'd3, 32'h18);
    add(1'b0, 1'b1, 32'hB3,     1'b0, 32'h0,      1'b0,  1'b1, 32'hB0,     32'hC,      3'd4, 32'h1C);
    add(1'b0, 1'b1, 32'hB4,     1'b0, 32'h0,      1'b0,  1'b1, 32'hB0,     32'hC,      3'd4, 32'h1C);
    add(1'b0, 1'b1, 32'hB5,     1'b0, 32'h0,      1'b0,  1'b1, 32'hB0,     32'hC,      3'd4, 32'h1C);
    // full with pop: push allowed, occupancy stays at 4
    add(1'b0, 1'b1, 32'hB4,     1'b0, 32'h0,      1'b1,  1'b1, 32'hB1,     32'h10,     3'd4, 32'h20);
    add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0,  1'b1, 32'hB1,     32'h10,     3'd4, 32'h20);
    add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1,  1'b1, 32'hB2,     32'h14,     3'd3, 32'h20);
    // redirect at occupancy 3 with a ROM word in the same cycle
    add(1'b0, 1'b1, 32'hDEAD,   1'b1, 32'h203,    1'b0,  1'b0, 32'hB2,     32'h14,     3'd0, 32'h200);
    // back-to-back redirects: last one wins, nothing pushed between
    add(1'b0, 1'b1, 32'hDEAD,   1'b1, 32'h300,    1'b0,  1'b0, 32'hB2,     32'h14,     3'd0, 32'h300);
    add(1'b0, 1'b1, 32'hDEAD,   1'b1, 32'h402,    1'b0,  1'b0, 32'hB2,     32'h14,     3'd0, 32'h400);
    add(1'b0, 1'b1, 32'hC0,     1'b0, 32'h0,      1'b0,  1'b1, 32'hC0,     32'h400,    3'd1, 32'h404);
    // ROM stall: queue drains, address stable, ordering resumes
    add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1,  1'b0, 32'hC0,     32'h400,    3'd0, 32'h404);
    add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1,  1'b0, 32'hC0,     32'h400,    3'd0, 32'h404);
    add(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1,  1'b0, 32'hC0,     32'h400,    3'd0, 32'h404);
    add(1'b0, 1'b1, 32'hC1,     1'b0, 32'h0,      1'b1,  1'b1, 32'hC1,     32'h404,    3'd1, 32'h408);
    // redirect together with a pop
    add(1'b0, 1'b0, 32'h0,      1'b1, 32'h100,    1'b1,  1'b0, 32'hC1,     32'h404,    3'd0, 32'h100);
    // reset mid-operation at occupancy 2
    add(1'b0, 1'b1, 32'hD0,     1'b0, 32'h0,      1'b0,  1'b1, 32'hD0,     32'h100,    3'd1, 32'h104);
    add(1'b0, 1'b1, 32'hD1,     1'b0, 32'h0,      1'b0,  1'b1, 32'hD0,     32'h100,    3'd2, 32'h108);
    add(1'b1, 1'b1, 32'hD2,     1'b0, 32'h0,      1'b1,  1'b0, 32'h0,      32'h0,      3'd0, 32'h0);
    add(1'b0, 1'b1, 32'hE0,     1'b0, 32'h0,      1'b1,  1'b1, 32'hE0,     32'h0,      3'd1, 32'h4);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].dv, vecs[i].data, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
      chk($sformatf("row%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("row%0d out_instr", i), out_instr, vecs[i].e_instr);
      chk($sformatf("row%0d out_pc", i),    out_pc,    vecs[i].e_pc);
      chk($sformatf("row%0d occupancy", i), {29'h0, occupancy}, {29'h0, vecs[i].e_occ});
      chk($sformatf("row%0d i_address", i), i_address, vecs[i].e_addr);
    end

    // PC wrap-around on the instance reset to 0xFFFFFFF8.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("wrap reset addr", w_address, 32'hFFFF_FFF8);
    chk("wrap reset occ", {29'h0, w_occ}, 32'h0);
    drive(1'b0, 1'b1, 32'h11, 1'b0, 32'h0, 1'b0);
    chk("wrap push1 pc", w_pc, 32'hFFFF_FFF8);
    chk("wrap push1 addr", w_address, 32'hFFFF_FFFC);
    drive(1'b0, 1'b1, 32'h22, 1'b0, 32'h0, 1'b0);
    chk("wrap push2 addr", w_address, 32'h0);
    drive(1'b0, 1'b1, 32'h33, 1'b0, 32'h0, 1'b0);
    chk("wrap push3 addr", w_address, 32'h4);
    chk("wrap push3 occ", {29'h0, w_occ}, 32'h3);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("wrap pop1 pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap pop1 instr", w_instr, 32'h22);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("wrap pop2 pc", w_pc, 32'h0);
    chk("wrap pop2 instr", w_instr, 32'h33);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("wrap drained valid", {31'h0, w_valid}, 32'h0);
    chk("wrap drained pc hold", w_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
